pipelined_barrel_shifter: RTL
=============================

Name: pipelined_barrel_shifter

Overview:
- Parametrised, pipelined barrel shifter. Next generation of the team's 8-bit combinational barrel shifter.
- Supports four shift/rotate modes, any power-of-two width, and one register stage per shift level.
- Uses valid/ready handshakes on both ports, with bubble collapsing.
- Sits between an upstream datapath producer and a downstream consumer in ALU/DSP pipelines.

Parameters:
- WIDTH, 8, data width in bits; power of two, 2 or more.
- SHAMT_W, $clog2(WIDTH), shift-amount width and number of pipeline stages; derived, not overridden.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream presents a transaction.
- in_ready  output  1  block accepts a transaction this cycle.
- in_data  input  WIDTH  operand.
- in_shamt  input  SHAMT_W  shift amount, 0..WIDTH-1.
- in_mode  input  2  00 SLL, 01 SRL, 10 SRA, 11 ROR.
- out_valid  output  1  result available.
- out_ready  input  1  downstream accepts the result.
- out_data  output  WIDTH  shifted/rotated result.
- out_zero  output  1  out_data == 0; valid only with out_valid.

Behaviour:
- Reset (async assert, sync release): every stage valid clears to 0; out_valid=0, out_data=0, out_zero=1. in_ready=1 from the first cycle after release.
- Handshake:
  - Transfer occurs when valid && ready on the same edge.
  - in_data, in_shamt and in_mode are sampled only on an input transfer.
  - While out_valid && !out_ready, out_data and out_zero hold stable.
- Pipeline: SHAMT_W stages; stage k (k=0..SHAMT_W-1) applies a shift of 2^k when shamt bit k is set.
  - Each stage registers data, remaining shamt bits, mode and valid.
- Stage acceptance: stage k loads when it is empty, or when its content moves to stage k+1 (or out) in the same cycle. Bubbles therefore collapse.
  - in_ready equals the stage-0 load condition. It must not depend combinationally on in_valid.
- Latency: with out_ready held high, the result appears SHAMT_W cycles after the input transfer (3 for WIDTH=8).
  - Throughput is one result per cycle.
  - Results leave in strict input order.
- Arithmetic:
  - SLL fills zeros from the LSB side.
  - SRL fills zeros from the MSB side.
  - SRA fills with in_data[WIDTH-1], captured at input.
  - ROR: bits leaving the LSB re-enter at the MSB.
  - shamt=0 passes data unchanged in every mode.
- SLL implementation: bit-reverse at input, shift right logically, bit-reverse at output. Left and right use the same stage logic.
- Full pipeline: with out_ready=0 and all stages valid, in_ready=0. No data is lost or overwritten.
- Simultaneous events: if out_ready rises in the same cycle in_valid is asserted with a full pipeline, all stages advance and the input is accepted that cycle.
- Reset mid-operation: all in-flight transactions are discarded immediately. Nothing is emitted after release until a new input transfer completes its latency.
- out_zero is computed in the final stage from the final result and registered with it.

Decomposition:
- Package barrel_pkg holds:
  - Mode constants: MODE_SLL=2'b00, MODE_SRL=2'b01, MODE_SRA=2'b10, MODE_ROR=2'b11.
  - Mode typedef: 2-bit enum.
  - Stage payload struct: data, shamt, mode, fill bit.
- Sub-module shifter_stage, parametrised by WIDTH and stage index k:
  - One conditional 2^k shift/rotate.
  - One skid-free valid/ready register slice.
  - Instantiated SHAMT_W times in a generate loop.
- Top level contains the input/output bit-reversal muxes and the zero flag.

Test Plan (WIDTH=8, out_ready=1 unless stated):
- Walk in_data=8'b10000000 with SRL, shamt 0..7 -> results 10000000, 01000000, ... 00000001, each exactly 3 cycles after its transfer, back-to-back.
- SRA on 8'b10000000: shamt=3 -> 11110000; shamt=7 -> 11111111. SRL on 8'b10000000 with shamt=3 -> 00010000.
- ROR on 8'b10010001 with shamt=1 -> 11001000. SLL on 8'b10000001 with shamt=1 -> 00000010. SLL on 8'b10000000 with shamt=1 -> 00000000 with out_zero=1.
- Back-pressure: stream 5 inputs and hold out_ready=0 -> in_ready drops after 3 accepts and out_data holds stable. Release out_ready -> all results delivered in order with no loss or duplication.
- Bubble collapse: one input, out_ready=0 for 6 cycles, then a second input -> second input accepted while the first is stalled. Both results delivered in order on consecutive cycles once out_ready=1.
- Assert rst_n=0 for 1 cycle with 3 transactions in flight -> out_valid=0, out_data=0 immediately. No stale result appears afterwards; the next input yields the correct result 3 cycles after its transfer.

Source files
------------

// File: rtl/barrel_pkg.sv
// Shared types for the pipelined barrel shifter: shift modes and the per-stage
// control payload that travels alongside data and shift amount.
package barrel_pkg;

    typedef enum logic [1:0] {
        MODE_SLL = 2'b00,
        MODE_SRL = 2'b01,
        MODE_SRA = 2'b10,
        MODE_ROR = 2'b11
    } mode_e;

    // Data and shamt widths follow WIDTH, so they are carried as separate
    // parametrised fields in each stage; the width-independent part lives here.
    typedef struct packed {
        mode_e mode;
        logic  fill;
    } stage_ctrl_t;

endpackage

// File: rtl/shifter_stage.sv
// One barrel-shifter level: conditional 2^K right shift/rotate feeding a
// valid/ready register slice whose accept condition comes from the top.
module shifter_stage
    import barrel_pkg::*;
#(
    parameter int unsigned  WIDTH   = 8,
    parameter int unsigned  K       = 0,
    localparam int unsigned SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               up_valid,
    input  logic               up_ready,
    input  logic [WIDTH-1:0]   up_data,
    input  logic [SHAMT_W-1:0] up_shamt,
    input  stage_ctrl_t        up_ctrl,
    output logic               dn_valid,
    output logic [WIDTH-1:0]   dn_data,
    output logic [SHAMT_W-1:0] dn_shamt,
    output stage_ctrl_t        dn_ctrl,
    output logic [WIDTH-1:0]   shifted
);

    localparam int unsigned      AMT       = 1 << K;
    localparam logic [WIDTH-1:0] FILL_MASK = ~({WIDTH{1'b1}} >> AMT);

    logic               valid_q, valid_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic [SHAMT_W-1:0] shamt_q, shamt_d;
    stage_ctrl_t        ctrl_q, ctrl_d;
    logic               load;

    // SLL arrives bit-reversed, so it shares the logical right-shift path.
    always_comb begin
        shifted = up_data;
        if (up_shamt[K]) begin
            case (up_ctrl.mode)
                MODE_SRA: shifted = (up_data >> AMT) | (up_ctrl.fill ? FILL_MASK : '0);
                MODE_ROR: shifted = (up_data >> AMT) | (up_data << (WIDTH - AMT));
                default:  shifted = up_data >> AMT;
            endcase
        end
    end

    always_comb begin
        load    = up_valid && up_ready;
        valid_d = up_ready ? up_valid : valid_q;
        data_d  = data_q;
        shamt_d = shamt_q;
        ctrl_d  = ctrl_q;
        if (load) begin
            data_d  = shifted;
            shamt_d = up_shamt;
            ctrl_d  = up_ctrl;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            shamt_q <= '0;
            ctrl_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            shamt_q <= shamt_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign dn_valid = valid_q;
    assign dn_data  = data_q;
    assign dn_shamt = shamt_q;
    assign dn_ctrl  = ctrl_q;

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined barrel shifter (SLL/SRL/SRA/ROR), one register stage per shift
// level, valid/ready on both sides with bubble-collapsing stage acceptance.
module pipelined_barrel_shifter
    import barrel_pkg::*;
#(
    parameter int unsigned  WIDTH   = 8,
    localparam int unsigned SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic [1:0]         in_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_zero
);

    logic [SHAMT_W:0]   valid;
    logic [SHAMT_W:0]   accept;
    logic [WIDTH-1:0]   data  [SHAMT_W+1];
    logic [SHAMT_W-1:0] shamt [SHAMT_W+1];
    stage_ctrl_t        ctrl  [SHAMT_W+1];
    logic [WIDTH-1:0]   in_data_eff;
    logic [WIDTH-1:0]   last_shifted;
    logic               last_load;
    logic               zero_q, zero_d;
    logic               unused_tail;

    always_comb begin
        in_data_eff = in_data;
        if (in_mode == MODE_SLL) begin
            for (int unsigned i = 0; i < WIDTH; i++) in_data_eff[i] = in_data[WIDTH-1-i];
        end
    end

    assign valid[0] = in_valid;
    assign data[0]  = in_data_eff;
    assign shamt[0] = in_shamt;
    assign ctrl[0]  = '{mode: mode_e'(in_mode), fill: in_data[WIDTH-1]};

    // Stage k accepts when empty or when its content moves on this cycle.
    always_comb begin
        accept          = '0;
        accept[SHAMT_W] = out_ready;
        for (int unsigned i = SHAMT_W; i > 0; i--) accept[i-1] = !valid[i] || accept[i];
    end

    for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
        logic [WIDTH-1:0] shifted;
        shifter_stage #(.WIDTH(WIDTH), .K(k)) u_stage (
            .clk      (clk),
            .rst_n    (rst_n),
            .up_valid (valid[k]),
            .up_ready (accept[k]),
            .up_data  (data[k]),
            .up_shamt (shamt[k]),
            .up_ctrl  (ctrl[k]),
            .dn_valid (valid[k+1]),
            .dn_data  (data[k+1]),
            .dn_shamt (shamt[k+1]),
            .dn_ctrl  (ctrl[k+1]),
            .shifted  (shifted)
        );
        if (k == SHAMT_W - 1) begin : g_last
            assign last_shifted = shifted;
        end else begin : g_mid
            logic unused_shifted;
            assign unused_shifted = ^shifted;
        end
    end

    assign last_load = valid[SHAMT_W-1] && accept[SHAMT_W-1];

    always_comb begin
        zero_d = zero_q;
        if (last_load) zero_d = (last_shifted == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) zero_q <= 1'b1;
        else        zero_q <= zero_d;
    end

    always_comb begin
        out_data = data[SHAMT_W];
        if (ctrl[SHAMT_W].mode == MODE_SLL) begin
            for (int unsigned i = 0; i < WIDTH; i++) out_data[i] = data[SHAMT_W][WIDTH-1-i];
        end
    end

    assign in_ready    = accept[0];
    assign out_valid   = valid[SHAMT_W];
    assign out_zero    = zero_q;
    assign unused_tail = ^{shamt[SHAMT_W], ctrl[SHAMT_W].fill};

endmodule
